// File: rtl/max7219_cmd_loader.sv
// Packs a byte stream of MAX7219 command frames into 16-bit words, writes them into the
// cmd_decod RAM, then launches playback and waits for completion, discard or timeout.
module max7219_cmd_loader #(
  parameter int G_RAM_ADDR_WIDTH = 8,
  parameter int G_BASE_ADDR      = 0,
  parameter int G_MAX_WORDS      = 64,
  parameter int G_TIMEOUT        = 2**20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_en,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [7:0]                  i_data,
  input  logic                        i_last,
  input  logic                        i_loop,
  output logic                        o_me,
  output logic                        o_we,
  output logic [G_RAM_ADDR_WIDTH-1:0] o_addr,
  output logic [15:0]                 o_wdata,
  output logic [G_RAM_ADDR_WIDTH-1:0] o_start_ptr,
  output logic [G_RAM_ADDR_WIDTH-1:0] o_last_ptr,
  output logic                        o_ptr_val,
  output logic                        o_loop,
  input  logic                        i_ptr_equality,
  input  logic                        i_discard,
  output logic                        o_busy,
  output logic                        o_frame_err
);

  localparam int AW = G_RAM_ADDR_WIDTH;
  localparam int IW = $clog2(G_MAX_WORDS + 1);
  localparam logic [AW-1:0] BASE     = AW'(G_BASE_ADDR);
  localparam logic [IW-1:0] MAXW     = IW'(G_MAX_WORDS);
  localparam logic [31:0]   TMO_LAST = 32'(G_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_MSB  = 3'd1,
    S_LOAD_LSB  = 3'd2,
    S_WRITE     = 3'd3,
    S_LAUNCH    = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_FLUSH     = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   word_idx_q;
  logic [15:0]     wdata_q;
  logic            frame_last_q;
  logic            ptr_eq_q;
  logic            frame_err_q;
  logic [31:0]     tmo_cnt_q;
  logic [AW-1:0]   start_ptr_q;
  logic [AW-1:0]   last_ptr_q;
  logic            loop_q;

  logic            ready_s;
  logic            write_s;
  logic            launch_s;
  logic            accept_s;
  logic            err_s;
  logic            ptr_rise_s;
  logic            tmo_hit_s;
  logic [AW-1:0]   wr_addr_s;
  logic [AW-1:0]   last_ptr_s;

  assign accept_s   = i_valid & ready_s;
  assign ptr_rise_s = i_ptr_equality & ~ptr_eq_q;
  assign tmo_hit_s  = (tmo_cnt_q == TMO_LAST);
  // Address arithmetic wraps modulo the RAM size; during LAUNCH word_idx holds the word count.
  assign wr_addr_s  = BASE + AW'(word_idx_q);
  assign last_ptr_s = wr_addr_s - AW'(1'b1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and error-event decode
  always_comb begin
    state_d = state_q;
    err_s   = 1'b0;
    if (!i_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_LOAD_MSB;
        S_LOAD_MSB: begin
          if (!accept_s) begin
            state_d = state_q;
          end else if (word_idx_q == MAXW) begin
            if (i_last) begin
              state_d = S_IDLE;
              err_s   = 1'b1;
            end else begin
              state_d = S_FLUSH;
            end
          end else if (i_last) begin
            state_d = S_IDLE;
            err_s   = 1'b1;
          end else begin
            state_d = S_LOAD_LSB;
          end
        end
        S_LOAD_LSB: begin
          if (accept_s) begin
            state_d = S_WRITE;
          end else begin
            state_d = state_q;
          end
        end
        S_WRITE: state_d = frame_last_q ? S_LAUNCH : S_LOAD_MSB;
        S_LAUNCH: state_d = i_loop ? S_IDLE : S_WAIT_DONE;
        // Discard beats a simultaneous ptr_equality edge so the rejection is reported.
        S_WAIT_DONE: begin
          if (i_discard || tmo_hit_s) begin
            state_d = S_IDLE;
            err_s   = 1'b1;
          end else if (ptr_rise_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        S_FLUSH: begin
          if (accept_s && i_last) begin
            state_d = S_IDLE;
            err_s   = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the current state
  always_comb begin
    ready_s  = 1'b0;
    write_s  = 1'b0;
    launch_s = 1'b0;
    case (state_q)
      S_LOAD_MSB, S_LOAD_LSB, S_FLUSH: ready_s = i_en;
      S_WRITE:                         write_s = i_en;
      S_LAUNCH:                        launch_s = i_en;
      default: begin
        ready_s  = 1'b0;
        write_s  = 1'b0;
        launch_s = 1'b0;
      end
    endcase
  end

  // Word packing, word counter, edge detect, timeout and held launch pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx_q   <= '0;
      wdata_q      <= 16'h0000;
      frame_last_q <= 1'b0;
      ptr_eq_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      tmo_cnt_q    <= 32'd0;
      start_ptr_q  <= '0;
      last_ptr_q   <= '0;
      loop_q       <= 1'b0;
    end else begin
      ptr_eq_q    <= i_ptr_equality;
      frame_err_q <= err_s;
      if (state_q == S_IDLE) begin
        word_idx_q <= '0;
      end else if (write_s) begin
        word_idx_q <= word_idx_q + IW'(1);
      end
      if (accept_s && state_q == S_LOAD_MSB) begin
        wdata_q[15:8] <= i_data;
      end
      if (accept_s && state_q == S_LOAD_LSB) begin
        wdata_q[7:0] <= i_data;
        frame_last_q <= i_last;
      end
      if (state_q == S_WAIT_DONE && i_en) begin
        tmo_cnt_q <= tmo_cnt_q + 32'd1;
      end else begin
        tmo_cnt_q <= 32'd0;
      end
      if (launch_s) begin
        start_ptr_q <= BASE;
        last_ptr_q  <= last_ptr_s;
        loop_q      <= i_loop;
      end
    end
  end

  assign o_ready     = ready_s;
  assign o_me        = write_s;
  assign o_we        = write_s;
  assign o_addr      = write_s ? wr_addr_s : '0;
  assign o_wdata     = write_s ? wdata_q : 16'h0000;
  assign o_ptr_val   = launch_s;
  assign o_start_ptr = launch_s ? BASE : start_ptr_q;
  assign o_last_ptr  = launch_s ? last_ptr_s : last_ptr_q;
  assign o_loop      = launch_s ? i_loop : loop_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_frame_err = frame_err_q;

endmodule
